// File: rtl/eth_fcs_check_pkg.sv
// Shared constants and types for the Ethernet FCS checker
// and its reusable CRC-32 byte step.
package eth_fcs_check_pkg;

    localparam int unsigned FCS_BYTES     = 4;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] fill_t;

endpackage

// File: rtl/crc32_d8_step.sv
// Combinational IEEE 802.3 CRC-32 (reflected) advance by one byte.
// Shared between the receive checker and the transmit generator.
module crc32_d8_step
    import eth_fcs_check_pkg::*;
(
    input  logic [31:0] crc,
    input  byte_t       data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0]) begin
                crc_next = (crc_next >> 1) ^ CRC32_POLY;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_fcs_check.sv
// Ethernet FCS checker: holds the trailing 4 bytes back, strips the FCS
// and flags the last payload beat when the CRC residue is wrong.
module eth_fcs_check
    import eth_fcs_check_pkg::*;
(
    input  logic       clk,
    input  logic       sreset,
    output logic       in_axis_tready,
    input  logic       in_axis_tvalid,
    input  logic       in_axis_tlast,
    input  logic [7:0] in_axis_tdata,
    input  logic       out_axis_tready,
    output logic       out_axis_tvalid,
    output logic       out_axis_tlast,
    output logic [7:0] out_axis_tdata,
    output logic       out_axis_tuser,
    output logic       fcs_ok,
    output logic       fcs_err,
    output logic       runt
);

    localparam fill_t FULL = fill_t'(FCS_BYTES);

    logic [FCS_BYTES-1:0][7:0] hold;
    fill_t       count;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic        steady;
    logic        accept;
    logic        good;

    crc32_d8_step u_crc (
        .crc      (crc),
        .data     (in_axis_tdata),
        .crc_next (crc_next)
    );

    assign steady = (count == FULL);
    assign accept = in_axis_tvalid & in_axis_tready;
    assign good   = (crc_next == CRC32_RESIDUE);

    // Once the hold is full the block is a straight wire with a 4-byte skew.
    assign in_axis_tready  = steady ? out_axis_tready : 1'b1;
    assign out_axis_tvalid = steady & in_axis_tvalid;
    assign out_axis_tdata  = hold[FCS_BYTES-1];
    assign out_axis_tlast  = steady & in_axis_tlast;
    assign out_axis_tuser  = steady & in_axis_tlast & ~good;

    always_ff @(posedge clk) begin
        fcs_ok  <= 1'b0;
        fcs_err <= 1'b0;
        runt    <= 1'b0;
        if (sreset) begin
            count <= '0;
            crc   <= CRC32_INIT;
        end else if (accept) begin
            hold <= {hold[FCS_BYTES-2:0], in_axis_tdata};
            if (in_axis_tlast) begin
                count   <= '0;
                crc     <= CRC32_INIT;
                fcs_ok  <= steady & good;
                fcs_err <= steady & ~good;
                runt    <= ~steady;
            end else begin
                crc <= crc_next;
                if (!steady) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/eth_fcs_check.md
ETH_FCS_CHECK -- requirements
Module: eth_fcs_check

Interface
REQ-001 SHALL have no parameters; data width is fixed at 8 bits and FCS length at 4 bytes.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 sreset  input  1  synchronous, active-high reset.
REQ-004 in_axis_tready  output  1  input beat accepted when high with in_axis_tvalid.
REQ-005 in_axis_tvalid  input  1  input byte valid.
REQ-006 in_axis_tlast  input  1  last byte of frame (last FCS byte).
REQ-007 in_axis_tdata  input  8  frame byte, payload then 4 FCS bytes, FCS least-significant byte first.
REQ-008 out_axis_tready  input  1  downstream ready.
REQ-009 out_axis_tvalid  output  1  payload byte valid.
REQ-010 out_axis_tlast  output  1  last payload byte.
REQ-011 out_axis_tdata  output  8  payload byte, FCS stripped.
REQ-012 out_axis_tuser  output  1  on the tlast beat: 1 = FCS mismatch; 0 on all other beats.
REQ-013 fcs_ok  output  1  one-cycle pulse when a frame with correct FCS completes.
REQ-014 fcs_err  output  1  one-cycle pulse when a frame with bad FCS completes.
REQ-015 runt  output  1  one-cycle pulse when a frame of fewer than 5 bytes is dropped.

Function
REQ-016 SHALL hold a 4-byte delay buffer plus fill count (0..4); accepted bytes shift in, oldest shifts out.
REQ-017 Fill (count<4): in_axis_tready=1, out_axis_tvalid=0; accepted non-last byte increments count.
REQ-018 Steady (count==4): out_axis_tvalid=in_axis_tvalid, out_axis_tdata=oldest buffer byte, in_axis_tready=out_axis_tready; zero added latency beyond the 4-byte hold.
REQ-019 out_axis_tlast SHALL equal in_axis_tlast in steady state; one input beat consumed per output beat, no loss or duplication under any tvalid/tready pattern.
REQ-020 CRC SHALL be IEEE 802.3 CRC-32, reflected, init 0xFFFFFFFF, computed over every accepted byte including FCS using the 8-bit parallel step.
REQ-021 Frame good iff CRC register (before final inversion) after the tlast byte equals residue 0xDEBB20E3.
REQ-022 out_axis_tuser on the tlast beat SHALL be the result of REQ-021 using the next-state CRC (includes the current byte).
REQ-023 On tlast handshake in steady state: fcs_ok or fcs_err pulses the following cycle; count→0, CRC→0xFFFFFFFF.
REQ-024 tlast accepted with count<4 (frame ≤4 bytes): no output beat, runt pulses next cycle, count→0, CRC→init.
REQ-025 Exactly 5-byte frame SHALL emit one payload byte with tlast.
REQ-026 Back-to-back frames SHALL run with no idle cycle between tlast and the next frame's first byte.
REQ-027 Status pulses SHALL be mutually exclusive and never asserted outside REQ-023/REQ-024.

Reset
REQ-028 sreset SHALL set count=0, CRC=0xFFFFFFFF, fcs_ok=fcs_err=runt=0; out_axis_tvalid=0 while count<4.
REQ-029 sreset mid-frame SHALL discard buffered bytes with no tlast emitted; next accepted byte starts a new frame.
REQ-030 sreset SHALL take priority over a simultaneous handshake.

Structure
REQ-031 Shared package SHALL hold CRC32_INIT=0xFFFFFFFF, CRC32_RESIDUE=0xDEBB20E3, FCS_BYTES=4.
REQ-032 CRC next-state SHALL be a combinational sub-module crc32_d8_step (crc in, byte in, crc out), reusable by the transmit side.

Verification
REQ-033 Bytes "123456789" (0x31..0x39) + 0x26 0x39 0xF4 0xCB -> 9 output bytes 0x31..0x39, tlast on 0x39, tuser=0, fcs_ok pulse.
REQ-034 Same frame, last byte 0xCA -> same 9 bytes, tuser=1 on 0x39, fcs_err pulse.
REQ-035 3-byte frame then REQ-033 frame -> no output for first, runt pulse, second frame passes clean.
REQ-036 REQ-033 frame with random in_tvalid gaps and out_tready toggling every cycle -> identical output sequence, no drop/duplicate.
REQ-037 sreset after 6 bytes of a frame, then REQ-033 frame -> no tlast from aborted frame, REQ-033 result exactly.
REQ-038 Two REQ-033 frames back-to-back, tvalid/tready held high -> 18 output bytes, two tlast, two fcs_ok pulses.
